// File: rtl/zigzag_rle_encoder.sv
// Buffers one 8x8 quantized block and emits zigzag (run, value) pairs.
// Optional ZRL_EN: zero runs of 16 emit a (15, 0) ZRL beat.
module zigzag_rle_encoder #(
  parameter int HDATA_BIT      = 12,
  parameter int RUN_BIT        = 6,
  parameter int BLOCK_BIT      = 3,
  parameter int BLOCK_AREA     = 64,
  parameter int BLOCK_AREA_BIT = 6
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic signed [HDATA_BIT-1:0] ct_veri_i,
  input  logic [BLOCK_BIT-1:0]        ct_row_i,
  input  logic [BLOCK_BIT-1:0]        ct_col_i,
  input  logic                        ct_gecerli_i,
  input  logic                        ct_blok_son_i,
  output logic                        ct_hazir_o,
  output logic [RUN_BIT-1:0]          hd_run_o,
  output logic signed [HDATA_BIT-1:0] hd_veri_o,
  output logic                        hd_gecerli_o,
  output logic                        hd_blok_son_o,
  input  logic                        hd_hazir_i
);

  // raster (row*8+col) -> zigzag index
  localparam int ZZ_ROM [64] = '{
     0,  1,  5,  6, 14, 15, 27, 28,
     2,  4,  7, 13, 16, 26, 29, 42,
     3,  8, 12, 17, 25, 30, 41, 43,
     9, 11, 18, 24, 31, 40, 44, 53,
    10, 19, 23, 32, 39, 45, 52, 54,
    20, 22, 33, 38, 46, 51, 55, 60,
    21, 34, 37, 47, 50, 56, 59, 61,
    35, 36, 48, 49, 57, 58, 62, 63
  };

  typedef enum logic [1:0] {
    DOLDUR,
    HAZIRLA,
    TARA
  } state_t;

  state_t state_r, state_n;

  logic signed [HDATA_BIT-1:0] coef_r [BLOCK_AREA];
  logic [BLOCK_AREA-1:0]       nz_r;
  logic [BLOCK_AREA_BIT-1:0]   son_idx_r, son_idx_n;
  logic [BLOCK_AREA_BIT-1:0]   ptr_r;
  logic [5:0]                  run_r;
  logic [BLOCK_AREA_BIT-1:0]   wr_zz;

  logic       accept;
  logic       step;
  logic       is_dc;
  logic       pos_nz;
  logic       is_zrl;
  logic       emit;
  logic       at_end;
  logic [5:0] run_out;

  assign ct_hazir_o = (state_r == DOLDUR);
  assign accept     = ct_gecerli_i && ct_hazir_o;
  assign wr_zz      = BLOCK_AREA_BIT'(ZZ_ROM[{ct_row_i, ct_col_i}]);

  always_comb begin
    son_idx_n = '0;
    for (int i = 0; i < BLOCK_AREA; i++) begin
      if (nz_r[i]) son_idx_n = BLOCK_AREA_BIT'(i);
    end
  end

  assign step   = (state_r == TARA) && (!hd_gecerli_o || hd_hazir_i);
  assign is_dc  = (ptr_r == '0);
  assign pos_nz = nz_r[ptr_r];
  assign at_end = (ptr_r == son_idx_r);

`ifdef ZRL_EN
  assign is_zrl = !is_dc && !pos_nz && (run_r == 6'd15);
`else
  assign is_zrl = 1'b0;
`endif

  assign emit    = is_dc || pos_nz || is_zrl;
  assign run_out = is_dc ? 6'd0 : run_r;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) state_r <= DOLDUR;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      DOLDUR:  if (accept && ct_blok_son_i) state_n = HAZIRLA;
      HAZIRLA: state_n = TARA;
      TARA:    if (step && at_end) state_n = DOLDUR;
      default: state_n = DOLDUR;
    endcase
  end

  // value storage is never cleared; nz_r masks stale entries
  always_ff @(posedge clk_i) begin
    if (accept) coef_r[wr_zz] <= ct_veri_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      nz_r          <= '0;
      son_idx_r     <= '0;
      ptr_r         <= '0;
      run_r         <= '0;
      hd_gecerli_o  <= 1'b0;
      hd_blok_son_o <= 1'b0;
      hd_run_o      <= '0;
      hd_veri_o     <= '0;
    end else begin
      if (accept) nz_r[wr_zz] <= (ct_veri_i != '0);
      if (state_r == HAZIRLA) begin
        son_idx_r <= son_idx_n;
        ptr_r     <= '0;
        run_r     <= '0;
      end
      if (step) begin
        run_r <= emit ? 6'd0 : run_r + 6'd1;
        if (at_end) nz_r  <= '0;
        else        ptr_r <= ptr_r + 1'b1;
      end
      if (step && emit) begin
        hd_gecerli_o  <= 1'b1;
        hd_blok_son_o <= at_end;
        hd_run_o      <= RUN_BIT'(run_out);
        hd_veri_o     <= pos_nz ? coef_r[ptr_r] : '0;
      end else if (hd_hazir_i) begin
        hd_gecerli_o <= 1'b0;
      end
    end
  end

endmodule
